// File: rtl/wd_fail_handler.sv
// wd_fail_handler: consumes the watchdog detector's WDFAIL/FLSTAT outputs.
// Synchronises the asynchronous fail flag, latches the fault code and counts
// failures. A failure raises a timed system-reset pulse and keeps the system
// in safe state. Repeated failures or a firmware-override fault escalate to a
// sticky lockout, which only CLRLOCK releases.
//
// Ports:
//   CLK      system clock
//   RST      synchronous active-high reset, overrides every other input
//   WDFAIL   fail flag from the detector, asynchronous to CLK
//   FLSTAT   3-bit fault code from the detector
//   FLACK    single-cycle firmware acknowledge
//   CLRLOCK  single-cycle firmware lockout clear
//   SYSRST   system reset pulse
//   SAFEST   safe-state enable
//   LOCKOUT  sticky lockout indicator
//   FLVALID  FLCODE holds an unacknowledged fault
//   FLCODE   latched fault code
//   FLCNT    failure count, saturating at 15
module wd_fail_handler #(
    parameter int unsigned FAIL_LIMIT    = 3,
    parameter int unsigned RST_PULSE_LEN = 16,
    parameter int unsigned HOLDOFF_CYC   = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WDFAIL,
    input  logic [2:0] FLSTAT,
    input  logic       FLACK,
    input  logic       CLRLOCK,
    output logic       SYSRST,
    output logic       SAFEST,
    output logic       LOCKOUT,
    output logic       FLVALID,
    output logic [2:0] FLCODE,
    output logic [3:0] FLCNT
);

    localparam int unsigned PULSE_W = 8;
    localparam int unsigned HOLD_W  = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CODE_W  = 3;

    // Down-counters load N-1 on state entry so the state lasts exactly N cycles.
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(RST_PULSE_LEN - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_LIMIT  = CNT_W'(FAIL_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CODE_W-1:0]  CODE_NONE  = 3'b100;
    localparam logic [CODE_W-1:0]  CODE_FWOVR = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTPULSE,
        S_HOLDOFF,
        S_WAIT_ACK,
        S_LOCKED
    } state_e;

    state_e              state_q, state_d;
    logic                wdf_s1_q, wdf_s2_q, wdf_prev_q;
    logic [CODE_W-1:0]   fls_s1_q, fls_s2_q;
    logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                sysrst_q, sysrst_d;
    logic                safest_q, safest_d;
    logic                lockout_q, lockout_d;
    logic                flvalid_q, flvalid_d;
    logic [CODE_W-1:0]   flcode_q, flcode_d;
    logic [CNT_W-1:0]    flcnt_q, flcnt_d;

    logic                fail_evt;
    logic [CNT_W-1:0]    cnt_inc;

    // Rising edge of the synchronised fail flag.
    assign fail_evt = wdf_s2_q & ~wdf_prev_q;
    // Saturating increment of the failure count.
    assign cnt_inc  = (flcnt_q == CNT_MAX) ? flcnt_q : flcnt_q + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        flvalid_d   = flvalid_q;
        flcode_d    = flcode_q;
        flcnt_d     = flcnt_q;

        case (state_q)
            S_IDLE: begin
                if (fail_evt) begin
                    // A simultaneous FLACK loses to the new event.
                    flcode_d  = fls_s2_q;
                    flvalid_d = 1'b1;
                    flcnt_d   = cnt_inc;
                    if (fls_s2_q == CODE_FWOVR || cnt_inc >= CNT_LIMIT) begin
                        state_d = S_LOCKED;
                    end else begin
                        state_d     = S_RSTPULSE;
                        pulse_cnt_d = PULSE_LOAD;
                    end
                end else if (FLACK) begin
                    flvalid_d = 1'b0;
                end
            end
            S_RSTPULSE: begin
                if (pulse_cnt_q == '0) begin
                    state_d    = S_HOLDOFF;
                    hold_cnt_d = HOLD_LOAD;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
                end
            end
            S_HOLDOFF: begin
                if (hold_cnt_q == '0) begin
                    state_d = wdf_s2_q ? S_WAIT_ACK : S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            S_WAIT_ACK: begin
                if (FLACK && !wdf_s2_q) begin
                    state_d   = S_IDLE;
                    flvalid_d = 1'b0;
                end
            end
            S_LOCKED: begin
                if (CLRLOCK && !wdf_s2_q) begin
                    state_d   = S_IDLE;
                    flcnt_d   = '0;
                    flvalid_d = 1'b0;
                    flcode_d  = CODE_NONE;
                end else if (FLACK) begin
                    flvalid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the state being entered so they stay registered.
        sysrst_d  = (state_d == S_RSTPULSE);
        safest_d  = (state_d != S_IDLE);
        lockout_d = (state_d == S_LOCKED);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            wdf_s1_q    <= 1'b0;
            wdf_s2_q    <= 1'b0;
            wdf_prev_q  <= 1'b0;
            fls_s1_q    <= CODE_NONE;
            fls_s2_q    <= CODE_NONE;
            pulse_cnt_q <= '0;
            hold_cnt_q  <= '0;
            sysrst_q    <= 1'b0;
            safest_q    <= 1'b0;
            lockout_q   <= 1'b0;
            flvalid_q   <= 1'b0;
            flcode_q    <= CODE_NONE;
            flcnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            wdf_s1_q    <= WDFAIL;
            wdf_s2_q    <= wdf_s1_q;
            wdf_prev_q  <= wdf_s2_q;
            fls_s1_q    <= FLSTAT;
            fls_s2_q    <= fls_s1_q;
            pulse_cnt_q <= pulse_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            sysrst_q    <= sysrst_d;
            safest_q    <= safest_d;
            lockout_q   <= lockout_d;
            flvalid_q   <= flvalid_d;
            flcode_q    <= flcode_d;
            flcnt_q     <= flcnt_d;
        end
    end

    assign SYSRST  = sysrst_q;
    assign SAFEST  = safest_q;
    assign LOCKOUT = lockout_q;
    assign FLVALID = flvalid_q;
    assign FLCODE  = flcode_q;
    assign FLCNT   = flcnt_q;

endmodule

// File: tb/tb_wd_fail_handler.sv
// Testbench for wd_fail_handler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model that tracks the handler's
// mode with absolute cycle deadlines.
module tb_wd_fail_handler;

    localparam int unsigned FAIL_LIMIT    = 3;
    localparam int unsigned RST_PULSE_LEN = 16;
    localparam int unsigned HOLDOFF_CYC   = 32;

    localparam int M_IDLE = 0, M_PULSE = 1, M_HOLD = 2, M_WACK = 3, M_LOCK = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WDFAIL = 1'b0;
    logic [2:0] FLSTAT = 3'b100;
    logic       FLACK = 1'b0;
    logic       CLRLOCK = 1'b0;
    logic       SYSRST, SAFEST, LOCKOUT, FLVALID;
    logic [2:0] FLCODE;
    logic [3:0] FLCNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int   cyc = 0;
    int   m_mode = M_IDLE;
    int   m_code = 4;
    int   m_valid = 0;
    int   m_cnt = 0;
    int   pulse_end = 0;
    int   hold_end = 0;
    int   wq[$];
    int   fq[$];

    wd_fail_handler #(
        .FAIL_LIMIT   (FAIL_LIMIT),
        .RST_PULSE_LEN(RST_PULSE_LEN),
        .HOLDOFF_CYC  (HOLDOFF_CYC)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .WDFAIL (WDFAIL),
        .FLSTAT (FLSTAT),
        .FLACK  (FLACK),
        .CLRLOCK(CLRLOCK),
        .SYSRST (SYSRST),
        .SAFEST (SAFEST),
        .LOCKOUT(LOCKOUT),
        .FLVALID(FLVALID),
        .FLCODE (FLCODE),
        .FLCNT  (FLCNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at it.
    // The controller sees WDFAIL/FLSTAT two edges late; an event is a 0->1
    // step in that delayed stream.
    task automatic model_edge();
        int s, p, c;
        cyc++;
        if (RST) begin
            m_mode = M_IDLE; m_valid = 0; m_code = 4; m_cnt = 0;
            wq = {0, 0, 0};
            fq = {4, 4, 4};
            return;
        end
        s = wq[wq.size()-2];
        p = wq[wq.size()-3];
        c = fq[fq.size()-2];
        wq.push_back(int'(WDFAIL));
        fq.push_back(int'(FLSTAT));
        if (wq.size() > 4) begin
            void'(wq.pop_front());
            void'(fq.pop_front());
        end
        case (m_mode)
            M_IDLE: begin
                if (s == 1 && p == 0) begin
                    m_code = c;
                    m_valid = 1;
                    if (m_cnt < 15) m_cnt = m_cnt + 1;
                    if (c == 0 || m_cnt >= int'(FAIL_LIMIT)) m_mode = M_LOCK;
                    else begin
                        m_mode = M_PULSE;
                        pulse_end = cyc + int'(RST_PULSE_LEN);
                    end
                end else if (FLACK) m_valid = 0;
            end
            M_PULSE: if (cyc == pulse_end) begin
                m_mode = M_HOLD;
                hold_end = cyc + int'(HOLDOFF_CYC);
            end
            M_HOLD: if (cyc == hold_end) m_mode = (s == 1) ? M_WACK : M_IDLE;
            M_WACK: if (FLACK && s == 0) begin
                m_mode = M_IDLE;
                m_valid = 0;
            end
            default: begin
                if (CLRLOCK && s == 0) begin
                    m_mode = M_IDLE; m_cnt = 0; m_valid = 0; m_code = 4;
                end else if (FLACK) m_valid = 0;
            end
        endcase
    endtask

    // One clock: update model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_eq("SYSRST",  32'(SYSRST),  32'(m_mode == M_PULSE));
        check_eq("SAFEST",  32'(SAFEST),  32'(m_mode != M_IDLE));
        check_eq("LOCKOUT", 32'(LOCKOUT), 32'(m_mode == M_LOCK));
        check_eq("FLVALID", 32'(FLVALID), 32'(m_valid));
        check_eq("FLCODE",  32'(FLCODE),  32'(m_code));
        check_eq("FLCNT",   32'(FLCNT),   32'(m_cnt));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int sys_hi, drop_at;

        // Reset with WDFAIL high, then the held flag yields one event 2 edges later.
        RST = 1'b1; WDFAIL = 1'b1; FLSTAT = 3'b011;
        steps(2);
        check_eq("rst_sysrst", 32'(SYSRST), 32'd0);
        check_eq("rst_safest", 32'(SAFEST), 32'd0);
        check_eq("rst_flcode", 32'(FLCODE), 32'd4);
        check_eq("rst_flcnt",  32'(FLCNT),  32'd0);
        RST = 1'b0;
        step();
        check_eq("lat_k0_flvalid", 32'(FLVALID), 32'd0);
        step();
        check_eq("lat_k1_flvalid", 32'(FLVALID), 32'd0);
        step();
        check_eq("lat_k2_flcode",  32'(FLCODE),  32'd3);
        check_eq("lat_k2_flvalid", 32'(FLVALID), 32'd1);
        check_eq("lat_k2_flcnt",   32'(FLCNT),   32'd1);
        check_eq("lat_k2_sysrst",  32'(SYSRST),  32'd1);
        sys_hi = 1; drop_at = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == 3) WDFAIL = 1'b0;
            step();
            if (SYSRST === 1'b1) sys_hi++;
            if (SAFEST === 1'b0 && drop_at < 0) drop_at = i;
        end
        check_eq("pulse_len",   32'(sys_hi),  32'd16);
        check_eq("safest_drop", 32'(drop_at), 32'd48);
        FLACK = 1'b1; step(); FLACK = 1'b0;
        check_eq("ack_flvalid", 32'(FLVALID), 32'd0);

        // Second failure; extra pulses during RSTPULSE and HOLDOFF are ignored.
        FLSTAT = 3'b001; WDFAIL = 1'b1;
        steps(3);
        check_eq("f2_flcnt", 32'(FLCNT), 32'd2);
        WDFAIL = 1'b0; steps(2);
        WDFAIL = 1'b1; steps(4);
        WDFAIL = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) WDFAIL = 1'b1;
            if (i == 24) WDFAIL = 1'b0;
            step();
        end
        check_eq("f2_flcnt_hold", 32'(FLCNT),  32'd2);
        check_eq("f2_safest",     32'(SAFEST), 32'd0);

        // Third failure locks; CLRLOCK with WDFAIL high is ignored.
        FLSTAT = 3'b010; WDFAIL = 1'b1;
        steps(3);
        check_eq("lk_lockout", 32'(LOCKOUT), 32'd1);
        check_eq("lk_flcnt",   32'(FLCNT),   32'd3);
        check_eq("lk_sysrst",  32'(SYSRST),  32'd0);
        check_eq("lk_flcode",  32'(FLCODE),  32'd2);
        CLRLOCK = 1'b1; step(); CLRLOCK = 1'b0;
        check_eq("lk_clr_ign", 32'(LOCKOUT), 32'd1);
        WDFAIL = 1'b0; steps(3);
        CLRLOCK = 1'b1; step(); CLRLOCK = 1'b0;
        check_eq("clr_lockout", 32'(LOCKOUT), 32'd0);
        check_eq("clr_flcnt",   32'(FLCNT),   32'd0);
        check_eq("clr_flcode",  32'(FLCODE),  32'd4);
        check_eq("clr_safest",  32'(SAFEST),  32'd0);

        // Firmware override on the first failure locks immediately.
        FLSTAT = 3'b000; WDFAIL = 1'b1;
        steps(3);
        check_eq("fw_lockout", 32'(LOCKOUT), 32'd1);
        check_eq("fw_flcnt",   32'(FLCNT),   32'd1);
        check_eq("fw_sysrst",  32'(SYSRST),  32'd0);
        FLACK = 1'b1; step(); FLACK = 1'b0;
        check_eq("fw_ack_flvalid", 32'(FLVALID), 32'd0);
        check_eq("fw_ack_lockout", 32'(LOCKOUT), 32'd1);
        WDFAIL = 1'b0; steps(3);
        CLRLOCK = 1'b1; step(); CLRLOCK = 1'b0;
        check_eq("fw_clr_lockout", 32'(LOCKOUT), 32'd0);

        // WDFAIL held through HOLDOFF lands in WAIT_ACK.
        FLSTAT = 3'b011; WDFAIL = 1'b1;
        steps(3);
        check_eq("wa_sysrst", 32'(SYSRST), 32'd1);
        steps(48);
        check_eq("wa_safest", 32'(SAFEST), 32'd1);
        check_eq("wa_sysrst_lo", 32'(SYSRST), 32'd0);
        FLACK = 1'b1; step(); FLACK = 1'b0;
        check_eq("wa_ack_ign_safest",  32'(SAFEST),  32'd1);
        check_eq("wa_ack_ign_flvalid", 32'(FLVALID), 32'd1);
        WDFAIL = 1'b0; steps(3);
        FLACK = 1'b1; step(); FLACK = 1'b0;
        check_eq("wa_exit_safest",  32'(SAFEST),  32'd0);
        check_eq("wa_exit_flvalid", 32'(FLVALID), 32'd0);
        check_eq("wa_exit_flcnt",   32'(FLCNT),   32'd1);

        // RST in the middle of a reset pulse.
        FLSTAT = 3'b001; WDFAIL = 1'b1;
        steps(3);
        check_eq("mr_sysrst", 32'(SYSRST), 32'd1);
        steps(5);
        WDFAIL = 1'b0; RST = 1'b1; step(); RST = 1'b0;
        check_eq("mr_sysrst_lo", 32'(SYSRST),  32'd0);
        check_eq("mr_flcnt",     32'(FLCNT),   32'd0);
        check_eq("mr_flcode",    32'(FLCODE),  32'd4);
        check_eq("mr_flvalid",   32'(FLVALID), 32'd0);
        check_eq("mr_safest",    32'(SAFEST),  32'd0);
        steps(3);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) WDFAIL = ~WDFAIL;
            if ($urandom_range(0, 7) == 0) FLSTAT = 3'($urandom_range(0, 4));
            FLACK   = ($urandom_range(0, 15) == 0);
            CLRLOCK = ($urandom_range(0, 15) == 0);
            RST     = ($urandom_range(0, 499) == 0);
            step();
        end
        RST = 1'b0; FLACK = 1'b0; CLRLOCK = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wd_fail_handler.md
Name: wd_fail_handler

Overview:
- Downstream consumer of the watchdog fail detector's WDFAIL/FLSTAT outputs.
- Synchronises the asynchronous fail indication and latches the fault code.
- Counts failures, issues a timed system-reset pulse, and holds the system in safe state.
- Escalates to a sticky lockout after repeated failures or a firmware override fault; only an explicit clear releases lockout.

Parameters:
- FAIL_LIMIT, 3, failure count (including the current failure) at which the block enters LOCKED instead of issuing a reset; valid range 1..15.
- RST_PULSE_LEN, 16, SYSRST high time in CLK cycles; valid range 1..255.
- HOLDOFF_CYC, 255, cycles after the reset pulse during which new WDFAIL edges are ignored; valid range 1..65535.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous active-high reset.
- WDFAIL  input  1  fail flag from the detector; asynchronous to CLK.
- FLSTAT  input  3  fault code from the detector: 000 firmware override, 001 service with switch off, 010 double service, 011 missed service, 100 no fault.
- FLACK  input  1  single-cycle acknowledge from firmware.
- CLRLOCK  input  1  single-cycle lockout clear from firmware.
- SYSRST  output  1  system reset pulse.
- SAFEST  output  1  safe-state enable.
- LOCKOUT  output  1  sticky lockout indicator.
- FLVALID  output  1  high when FLCODE holds an unacknowledged fault.
- FLCODE  output  3  latched fault code.
- FLCNT  output  4  failure count, saturating at 15.

Behaviour:
- Reset (RST sampled high at a CLK edge):
  - State IDLE.
  - SYSRST, SAFEST, LOCKOUT, FLVALID = 0; FLCODE = 3'b100; FLCNT = 0.
  - Synchroniser stages: WDFAIL stages = 0, FLSTAT stages = 3'b100.
  - All counters = 0.
  - RST takes priority over every other input, in every state.
- Synchronisation:
  - WDFAIL and FLSTAT each pass through two flops.
  - A fail event is a rising edge of the synchronised WDFAIL (sync2 = 1, previous sync2 = 0).
- Latency: if WDFAIL is first sampled high at CLK edge k, FLCODE/FLVALID/FLCNT/SYSRST update at edge k+2.
- IDLE:
  - SAFEST = 0, SYSRST = 0.
  - FLACK clears FLVALID.
  - On a fail event:
    - FLCODE <= synchronised FLSTAT; FLVALID <= 1; FLCNT <= FLCNT+1 (saturating).
    - If the code is 000 or FLCNT+1 >= FAIL_LIMIT, go to LOCKED.
    - Otherwise go to RSTPULSE.
  - A fail event and FLACK in the same cycle: the event wins and FLVALID stays 1.
- RSTPULSE:
  - SYSRST = 1, SAFEST = 1 for exactly RST_PULSE_LEN cycles, then go to HOLDOFF.
- HOLDOFF:
  - SYSRST = 0, SAFEST = 1.
  - Fail events are ignored and the count is not incremented.
  - After HOLDOFF_CYC cycles: if synchronised WDFAIL = 0, go to IDLE; otherwise go to WAIT_ACK.
- WAIT_ACK:
  - SAFEST = 1.
  - Go to IDLE when FLACK = 1 and synchronised WDFAIL = 0 in the same cycle; FLVALID <= 0.
  - FLACK while WDFAIL is high is ignored.
- LOCKED:
  - SAFEST = 1, LOCKOUT = 1, SYSRST = 0.
  - Fail events are ignored.
  - FLACK clears FLVALID only.
  - CLRLOCK = 1 with synchronised WDFAIL = 0: go to IDLE, FLCNT <= 0, LOCKOUT <= 0, FLVALID <= 0, FLCODE <= 3'b100.
  - CLRLOCK while WDFAIL is high is ignored.
- CLRLOCK outside LOCKED has no effect.
- FLCNT is cleared only by RST or CLRLOCK; a successful recovery does not clear it.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths: RST_PULSE_LEN counter 8 bits; HOLDOFF counter 16 bits. Both reload on state entry.

Test Plan:
- Test parameters: FAIL_LIMIT = 3, RST_PULSE_LEN = 16, HOLDOFF_CYC = 32.
- RST for 2 cycles with WDFAIL = 1 -> all outputs zero, FLCODE = 100; after release, one event is captured 2 edges later.
- WDFAIL rises at edge k with FLSTAT = 011, then falls 5 cycles later -> at edge k+2: FLCODE = 011, FLVALID = 1, FLCNT = 1, SYSRST high for 16 cycles; SAFEST drops 16+32 cycles later; FLACK then clears FLVALID.
- Third failure with FLSTAT = 010 -> LOCKED at FLCNT = 3, no SYSRST pulse, LOCKOUT = 1; CLRLOCK while WDFAIL = 1 is ignored; CLRLOCK after WDFAIL = 0 -> IDLE, FLCNT = 0, FLCODE = 100.
- WDFAIL with FLSTAT = 000 on the first failure -> LOCKED immediately, FLCNT = 1, no SYSRST.
- WDFAIL held high through HOLDOFF -> WAIT_ACK with SAFEST = 1; FLACK with WDFAIL still high is ignored; FLACK after WDFAIL falls -> IDLE.
- Second WDFAIL pulse during RSTPULSE/HOLDOFF -> FLCNT unchanged; RST asserted mid-RSTPULSE -> SYSRST = 0 on the next edge and all state is cleared.
